// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory arbiter
package mem_arb_pkg;
  typedef enum logic {INIT, RUN} state_t;
  typedef logic req_id_t;
  localparam int NUM_REQ = 2;
  localparam int RD_LATENCY = 1;
endpackage

// File: rtl/mem_arb2_rr.sv
// rr_arb2: two-input round-robin grant; pointer moves to the loser after each transfer
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);
  req_id_t ptr_q, ptr_d;
  always_comb begin
    gnt = &req ? (ptr_q ? 2'b10 : 2'b01) : req;
    ptr_d = advance ? gnt[0] : ptr_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mem_arb2.sv
// mem_arb2: clears memory after reset, then arbitrates one access per cycle between
// two requesters and routes the registered read data back to the originator.
module mem_arb2
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SIZE_E     = 6,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0_VALID,
  input  logic              REQ0_WE,
  input  logic [SIZE_E-1:0] REQ0_ADDR,
  input  logic [WIDTH-1:0]  REQ0_WDATA,
  output logic              REQ0_READY,
  output logic              RSP0_VALID,
  output logic [WIDTH-1:0]  RSP0_DATA,
  input  logic              REQ1_VALID,
  input  logic              REQ1_WE,
  input  logic [SIZE_E-1:0] REQ1_ADDR,
  input  logic [WIDTH-1:0]  REQ1_WDATA,
  output logic              REQ1_READY,
  output logic              RSP1_VALID,
  output logic [WIDTH-1:0]  RSP1_DATA,
  output logic              M_WRITE,
  output logic [SIZE_E-1:0] M_WRADDR,
  output logic [WIDTH-1:0]  M_D,
  output logic              M_READ,
  output logic [SIZE_E-1:0] M_RDADDR,
  input  logic [WIDTH-1:0]  M_Q,
  output logic              BUSY
);
  state_t state_q, state_d;
  logic [SIZE_E-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  req_id_t pid_q, pid_d;
  logic [NUM_REQ-1:0] gnt;
  logic run, clr, fire, we, wr, rd;
  req_id_t gid;
  logic [SIZE_E-1:0] addr;
  logic [WIDTH-1:0] wdata;
  rr_arb2 u_arb (
    .CLK(CLK),
    .RST(RST),
    .req({REQ1_VALID, REQ0_VALID}),
    .advance(fire),
    .gnt(gnt)
  );
  // Strobes are gated by RST so the memory sees no access while reset is held.
  always_comb begin
    run = (state_q == RUN) & ~RST;
    clr = (state_q == INIT) & ~RST;
    fire = run & |gnt;
    gid = gnt[1];
    we = gid ? REQ1_WE : REQ0_WE;
    addr = gid ? REQ1_ADDR : REQ0_ADDR;
    wdata = gid ? REQ1_WDATA : REQ0_WDATA;
    wr = fire & we;
    rd = fire & ~we;
    REQ0_READY = run & gnt[0];
    REQ1_READY = run & gnt[1];
    M_WRITE = clr | wr;
    M_WRADDR = clr ? cnt_q : (wr ? addr : '0);
    M_D = wr ? wdata : '0;
    M_READ = rd;
    M_RDADDR = rd ? addr : '0;
    BUSY = state_q == INIT;
    RSP0_VALID = pend_q & ~pid_q;
    RSP1_VALID = pend_q & pid_q;
    RSP0_DATA = M_Q;
    RSP1_DATA = M_Q;
    cnt_d = clr ? cnt_q + 1'b1 : cnt_q;
    state_d = (clr & &cnt_q) ? RUN : state_q;
    pend_d = rd;
    pid_d = rd ? gid : pid_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= INIT_CLEAR ? INIT : RUN;
      cnt_q <= '0;
      pend_q <= 1'b0;
      pid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      pid_q <= pid_d;
    end
  end
endmodule
